// File: rtl/riscv_sim_pkg.sv
// Shared types and constants for the simulator core back end.
// ALU opcodes, FSM states and the captured-instruction record.
package riscv_sim_pkg;
    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int RIDX_W = $clog2(NREGS);

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;
    localparam logic [3:0] ALU_LW   = 4'd11;
    localparam logic [3:0] ALU_SW   = 4'd12;

    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_e;

    typedef struct packed {
        logic [RIDX_W-1:0] rd;
        logic [3:0]        op;
        logic              we;
        logic [XLEN-1:0]   imm;
    } instr_t;

    // Only ALU ops and loads produce a register result.
    function automatic logic writes_rd(input logic [3:0] op);
        return (op >= ALU_ADD) && (op <= ALU_LW);
    endfunction
endpackage

// File: rtl/execute_unit_if.sv
// Decode-in, data-memory and writeback signals of the execute unit.
// slave = execute unit, master = decode stage / memory / bench side.
interface execute_unit_if;
    import riscv_sim_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [RIDX_W-1:0] rd;
    logic [RIDX_W-1:0] rs1;
    logic [RIDX_W-1:0] rs2;
    logic [11:0]       immed;
    logic [3:0]        alu_op;
    logic              write_enable;

    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;

    logic              wb_valid;
    logic              wb_we;
    logic [RIDX_W-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;

    modport slave (
        input  in_valid, rd, rs1, rs2, immed, alu_op, write_enable, mem_ack, mem_rdata,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
               wb_valid, wb_we, wb_rd, wb_data
    );

    modport master (
        output in_valid, rd, rs1, rs2, immed, alu_op, write_enable, mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
               wb_valid, wb_we, wb_rd, wb_data
    );
endinterface

// File: rtl/regfile.sv
// Architectural register file: two combinational reads, one synchronous write.
// x0 is held at zero; rst clears every entry.
module regfile #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);
    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[wa] = wd;
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) regs_q <= '0;
        else     regs_q <= regs_d;
    end

    assign rd1 = regs_q[ra1];
    assign rd2 = regs_q[ra2];
endmodule

// File: rtl/execute_unit.sv
// Multi-cycle back end: captures one decoded instruction, runs it through
// the ALU or the data-memory port, and retires it with a one-cycle wb pulse.
module execute_unit
    import riscv_sim_pkg::*;
(
    input logic           clk,
    input logic           rst,
    execute_unit_if.slave bus
);
    localparam int SH_W = $clog2(XLEN);

    state_e          state_q, state_d;
    instr_t          ins_q, ins_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;

    logic              wb_valid_q, wb_valid_d;
    logic              wb_we_q, wb_we_d;
    logic [RIDX_W-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;

    logic [XLEN-1:0] rs1_val, rs2_val, alu_res, eff_addr;
    logic            is_mem, retire_we;

    regfile #(.NREGS(NREGS), .XLEN(XLEN)) u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (bus.rs1),
        .ra2 (bus.rs2),
        .rd1 (rs1_val),
        .rd2 (rs2_val),
        .we  (wb_valid_q & wb_we_q),
        .wa  (wb_rd_q),
        .wd  (wb_data_q)
    );

    // ADD doubles as ADDI: decode zeroes whichever of B / imm is unused.
    always_comb begin
        alu_res = '0;
        case (ins_q.op)
            ALU_ADD:  alu_res = a_q + b_q + ins_q.imm;
            ALU_SUB:  alu_res = a_q - b_q;
            ALU_XOR:  alu_res = a_q ^ b_q;
            ALU_OR:   alu_res = a_q | b_q;
            ALU_AND:  alu_res = a_q & b_q;
            ALU_SLL:  alu_res = a_q << b_q[SH_W-1:0];
            ALU_SRL:  alu_res = a_q >> b_q[SH_W-1:0];
            ALU_SRA:  alu_res = $signed(a_q) >>> b_q[SH_W-1:0];
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a_q < b_q)};
            default:  alu_res = '0;
        endcase
    end

    assign is_mem    = (ins_q.op == ALU_LW) || (ins_q.op == ALU_SW);
    assign retire_we = ins_q.we && (ins_q.rd != '0) && writes_rd(ins_q.op);
    assign eff_addr  = a_q + ins_q.imm;

    always_comb begin
        state_d    = state_q;
        ins_d      = ins_q;
        a_d        = a_q;
        b_d        = b_q;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = '0;
        wb_data_d  = '0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    ins_d.rd  = bus.rd;
                    ins_d.op  = bus.alu_op;
                    ins_d.we  = bus.write_enable;
                    ins_d.imm = {{(XLEN-12){bus.immed[11]}}, bus.immed};
                    a_d       = rs1_val;
                    b_d       = rs2_val;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (is_mem) begin
                    state_d = MEM;
                end else begin
                    state_d    = WB;
                    wb_valid_d = 1'b1;
                    wb_we_d    = retire_we;
                    wb_rd_d    = ins_q.rd;
                    wb_data_d  = alu_res;
                end
            end
            MEM: begin
                if (bus.mem_ack) begin
                    state_d    = WB;
                    wb_valid_d = 1'b1;
                    wb_we_d    = retire_we;
                    wb_rd_d    = ins_q.rd;
                    wb_data_d  = (ins_q.op == ALU_LW) ? bus.mem_rdata : '0;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ins_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ins_q      <= ins_d;
            a_q        <= a_d;
            b_q        <= b_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Request outputs derive only from held state, so they stay put until ack.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.mem_req   = (state_q == MEM);
    assign bus.mem_we    = bus.mem_req && (ins_q.op == ALU_SW);
    assign bus.mem_addr  = bus.mem_req ? eff_addr : '0;
    assign bus.mem_wdata = bus.mem_we ? b_q : '0;

    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_we    = wb_we_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;
endmodule

// File: doc/execute_unit.md
# execute_unit

Back-end stage of the multi-cycle RISC-V simulator core. It accepts one decoded instruction at a time (register indices, 12-bit immediate, 4-bit `alu_op`, `write_enable`) from the decode stage. It owns the architectural register file, executes ALU and load/store operations through a request/acknowledge data-memory port, and retires each instruction with a one-cycle writeback pulse.

## Interface
- `XLEN`, 32: datapath width.
- `NREGS`, 32: register count; index width is log2(`NREGS`) = 5.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: a decoded instruction is present.
- `in_ready` out 1: the unit is idle and can accept an instruction.
- `rd`, `rs1`, `rs2` in 5 each: register indices.
- `immed` in 12: immediate, sign-extended to `XLEN`.
- `alu_op` in 4: operation code, 1..12.
- `write_enable` in 1: instruction writes `rd`.
- `mem_req` out 1: data-memory request.
- `mem_we` out 1: 1 = store, 0 = load.
- `mem_addr` out 32: byte address.
- `mem_wdata` out 32: store data.
- `mem_ack` in 1: memory has completed the request.
- `mem_rdata` in 32: load data, valid when `mem_ack` = 1.
- `wb_valid` out 1: one-cycle retire pulse.
- `wb_we` out 1: register file written this cycle.
- `wb_rd` out 5: destination index.
- `wb_data` out 32: result.

## Operation
- FSM states are IDLE, EXEC, MEM, WB.
  - IDLE: `in_ready` = 1. On `in_valid`, capture `rd`, `alu_op`, `write_enable`, sext(`immed`), `A` = rf[`rs1`] and `B` = rf[`rs2`], then go to EXEC. `in_valid` is ignored in every other state.
  - EXEC: compute `res`. If `alu_op` is 11 or 12, go to MEM; otherwise go to WB.
  - MEM: `mem_req` = 1, and `mem_addr` = `A` + sext(imm). `mem_we` = 1 and `mem_wdata` = `B` for store (12); `mem_we` = 0 for load (11). All request outputs stay constant until `mem_ack`. On ack, latch `mem_rdata` as `res` for a load, then go to WB.
  - WB: `wb_valid` = 1. The register file is written at the end of this cycle if `wb_we` = 1. Next state is IDLE.
- `wb_we` = `write_enable` AND (`rd` != 0) AND `alu_op` not in {0, 12, 13, 14, 15}.
- ALU operations, modulo 2^32:
  - 1 ADD/ADDI: `A` + `B` + sext(imm). This works because decode zeroes unused fields: `B` = 0 for ADDI, imm = 0 for ADD.
  - 2 SUB: `A` − `B`.
  - 3 XOR, 4 OR, 5 AND: bitwise.
  - 6 SLL, 7 SRL: logical shifts by `B[4:0]`.
  - 8 SRA: arithmetic shift by `B[4:0]`.
  - 9 SLT: signed compare, result 0 or 1.
  - 10 SLTU: unsigned compare, result 0 or 1.
- `alu_op` 0 or 13–15: executed as a NOP. The instruction still retires (`wb_valid`) with `wb_we` = 0 and `wb_data` = 0.
- x0 reads as 0 always; writes to x0 are dropped.
- Alignment is not checked: `mem_addr[1:0]` is passed through unchanged.
- There is no timeout. MEM waits indefinitely for `mem_ack`.

## Timing
- Reset:
  - State goes to IDLE and every register file entry clears to 0.
  - Outputs: `in_ready` = 1, and `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `wb_valid`, `wb_we`, `wb_rd`, `wb_data` all 0.
- Reset asserted in any state, including MEM with a request outstanding, takes effect at the next edge. `mem_req` drops in the following cycle, and a later `mem_ack` is ignored.
- ALU instruction accepted at edge N:
  - EXEC during cycle N+1, WB during cycle N+2 (`wb_valid` high).
  - The register write is visible to an instruction accepted at edge N+3.
  - `in_ready` is high again in cycle N+3.
- Memory instruction: `mem_req` rises in cycle N+2. If `mem_ack` is sampled at edge M, WB occurs in cycle M+1.
- Read-after-write hazards cannot occur, because only one instruction is in flight at a time.
- `wb_*` outputs are registered and are 0 whenever `wb_valid` = 0.

## Structure
- Package `riscv_sim_pkg` holds:
  - `alu_op` localparams, `ALU_ADD` = 1 through `ALU_SW` = 12.
  - The FSM state enum.
  - `XLEN`.
- Sub-module `regfile`: `NREGS` × `XLEN`, two combinational read ports, one synchronous write port, x0 hardwired to 0, synchronous clear on `rst`.
- The ALU stays inline as a combinational case on `alu_op`.

## Test plan
- Reset, then ADDI with `rd` = 1, `rs1` = 0, `immed` = 0x005, `alu_op` = 1, accepted at edge N → `wb_valid` in cycle N+2 with `wb_rd` = 1, `wb_data` = 5, `wb_we` = 1. Reject `in_valid` asserted during EXEC.
- ADDI x2 = x1 + 0xFFF → 4. Then SUB x3 = x2 − x1 → 0xFFFFFFFF. SLT x4 = x3, x1 → 1. SLTU x5 = x3, x1 → 0. SRA x6 = x3 >> x1 → 0xFFFFFFFF.
- SW with `rs1` = 0, `rs2` = 1, imm = 0x010, ack delayed 3 cycles → `mem_req`, `mem_we` = 1, `mem_addr` = 0x10, `mem_wdata` = 5 held stable for all 3 cycles. Then `wb_valid` with `wb_we` = 0.
- LW x7 from 0x10(x0), `mem_rdata` = 0xDEADBEEF, ack after 2 cycles → `wb_data` = 0xDEADBEEF, `wb_we` = 1. A following ADD x8 = x7 + x0 → 0xDEADBEEF.
- ADD with `rd` = 0, and `alu_op` = 14 → both retire with `wb_we` = 0. A subsequent read of x0 returns 0.
- Assert `rst` during MEM with ack withheld → `mem_req` = 0 in the next cycle, `in_ready` = 1, x1 reads 0. A late `mem_ack` causes no writeback.
